ysyx_220053_imem: RTL and testbench
===================================

# ysyx_220053_imem

Instruction-memory responder: the memory-side end of the fetch interface. Accepts one fetch request at a time over a valid/ready handshake, waits a programmable latency, and returns the aligned 64-bit word plus the selected 32-bit instruction, or an access error. It sits between the fetch unit and an on-chip program store, which a test loader fills through a separate write port.

## Interface

Parameters:
- `ADDR_BASE`, default `64'h80000000`: byte address of word 0.
- `DEPTH_WORDS`, default `1024`: number of 64-bit words; must be a power of 2.
- `LATENCY`, default `2`: cycles from request acceptance to `resp_valid`; must be ≥ 1.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  1: fetch request present.
- `req_ready`  out  1: responder can accept a request.
- `req_addr`  in  64: fetch byte address.
- `resp_valid`  out  1: response present.
- `resp_ready`  in  1: requester consumes the response.
- `resp_rdata`  out  64: aligned 64-bit word containing `req_addr`.
- `resp_instr`  out  32: `resp_rdata[63:32]` if `addr[2]`, else `resp_rdata[31:0]`.
- `resp_err`  out  1: access fault, meaning misaligned or out of range.
- `ld_en`  in  1: loader write enable.
- `ld_idx`  in  log2(DEPTH_WORDS): loader word index.
- `ld_data`  in  64: loader write data.

## Operation

- FSM states: IDLE, WAIT, RESP.
- `req_ready` = (state == IDLE) & ~rst. No pipelining; one outstanding request.

IDLE:
- On `req_valid & req_ready`, latch `req_addr` and load `cnt = LATENCY-1`.
- If `LATENCY == 1`, go to RESP. Otherwise go to WAIT.

WAIT:
- `cnt` decrements each cycle.
- On the edge where `cnt == 1`, go to RESP.

Entering RESP, the response registers capture the following:
- Index: `idx = (addr - ADDR_BASE) >> 3`, using 64-bit subtraction.
- Range check: in range iff `addr >= ADDR_BASE` and `addr - ADDR_BASE < DEPTH_WORDS*8`.
- Misaligned iff `addr[1:0] != 0`.
- On error: `resp_err = 1`, `resp_rdata = 0`, `resp_instr = 0`.
- Otherwise: `resp_rdata = mem[idx]`, `resp_err = 0`.

RESP:
- `resp_valid = 1`. All `resp_*` outputs hold stable until `resp_ready`.
- On `resp_valid & resp_ready`, go to IDLE.

Loader:
- When `ld_en` is high, it writes `mem[ld_idx] = ld_data` on any edge, in any state.
- A write on the same edge as RESP capture is not visible in that response; the old data is returned.

Memory contents:
- Not affected by `rst`.
- Contents are undefined until loaded. Uninitialised reads return X in simulation.

## Timing

Reset:
- State goes to IDLE.
- `resp_valid = 0`, `resp_rdata = 0`, `resp_instr = 0`, `resp_err = 0`, `cnt = 0`.
- `req_ready = 0` while `rst` is high, and 1 in the first cycle after it drops.

Latency and throughput:
- Request accepted at edge t gives `resp_valid` high in the cycle after edge t+LATENCY-1, i.e. exactly LATENCY edges after acceptance.
- Back-to-back throughput is one request per LATENCY+1 cycles when `resp_ready` is tied high.
- `req_ready` is low throughout WAIT and RESP. A `req_valid` held there is accepted in the first IDLE cycle.

Reset mid-operation:
- `rst` in WAIT or RESP aborts the transaction.
- No response is produced; the outputs take their reset values.

Loader write timing:
- Same-index loader write during WAIT, before the capture edge: the response returns the new data.

## Structure

Shared package `ysyx_220053_imem_pkg` holds:
- State encoding enum: IDLE=0, WAIT=1, RESP=2.
- `IMEM_BASE_DEFAULT`.
- Width helper `IDX_W = $clog2(DEPTH_WORDS)`.

One sub-module, `ysyx_220053_imem_array`:
- DEPTH_WORDS×64 storage.
- One synchronous write port (the loader) and one combinational read port.

The top-level file contains the FSM, latency counter, address checks and response registers.

## Test plan

- **Basic fetch:** load `mem[0]=64'h00100093_00000513`, request `0x80000000`, LATENCY=2 → `resp_valid` 2 edges after acceptance, `resp_instr=0x00000513`, `resp_err=0`. Request `0x80000004` → `resp_instr=0x00100093`.
- **Backpressure:** hold `resp_ready=0` for 5 cycles → `resp_valid`/data stable and `req_ready=0` for all 5 cycles. Then raise `resp_ready` → IDLE and `req_ready=1` the next cycle.
- **Errors:** request `0x80000002` → `resp_err=1`, data 0. Request `0x7FFFFFFC` → `resp_err=1`. Request `0x80000000+DEPTH_WORDS*8` → `resp_err=1`. Request last word `+DEPTH_WORDS*8-4` → `resp_err=0`.
- **LATENCY=1 with `resp_ready` tied high:** three requests → responses every 2 cycles, in order, with correct data.
- **Load/read race:** write `ld_idx=5` during WAIT, before capture, for a request to `0x80000028` → new data returned. Write on the capture edge → old data returned.
- **Reset mid-WAIT:** assert `rst` for 1 cycle → no `resp_valid` ever for that request. All outputs zero, and memory contents preserved, as shown by a subsequent fetch returning the earlier-loaded data.

Source files
------------

// File: rtl/ysyx_220053_imem_pkg.sv
// rtl/ysyx_220053_imem_pkg.sv - shared types and constants for the instruction-memory responder
package ysyx_220053_imem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } imem_state_t;

    localparam logic [63:0] IMEM_BASE_DEFAULT  = 64'h8000_0000;
    localparam int unsigned IMEM_DEPTH_DEFAULT = 1024;
    localparam int unsigned IDX_W              = $clog2(IMEM_DEPTH_DEFAULT);

    // Word-index width for a given depth; never below 1 so port widths stay legal.
    function automatic int unsigned idx_w(input int unsigned depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/ysyx_220053_imem_array.sv
// rtl/ysyx_220053_imem_array.sv - program store, one synchronous write port and one combinational read port
//
// Ports:
//   clk      : clock
//   wr_en    : write enable (loader)
//   wr_idx   : write word index
//   wr_data  : write data
//   rd_idx   : read word index
//   rd_data  : combinational read data
//
// Contents are deliberately not reset.
module ysyx_220053_imem_array
    import ysyx_220053_imem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = IMEM_DEPTH_DEFAULT,
    parameter int unsigned AW          = idx_w(DEPTH_WORDS)
)(
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  logic [63:0]   wr_data,
    input  logic [AW-1:0] rd_idx,
    output logic [63:0]   rd_data
);

    logic [63:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/ysyx_220053_imem.sv
// rtl/ysyx_220053_imem.sv - fetch-side instruction memory responder with programmable latency
//
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   req_valid/req_ready       : fetch request handshake, req_addr = byte address
//   resp_valid/resp_ready     : response handshake
//   resp_rdata                : aligned 64-bit word holding the requested address
//   resp_instr                : 32-bit half selected by addr[2]
//   resp_err                  : misaligned or out-of-range access
//   ld_en, ld_idx, ld_data    : loader write port into the program store
module ysyx_220053_imem
    import ysyx_220053_imem_pkg::*;
#(
    parameter logic [63:0] ADDR_BASE   = IMEM_BASE_DEFAULT,
    parameter int unsigned DEPTH_WORDS = IMEM_DEPTH_DEFAULT,
    parameter int unsigned LATENCY     = 2,
    localparam int unsigned AW         = idx_w(DEPTH_WORDS)
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [63:0]   req_addr,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [63:0]   resp_rdata,
    output logic [31:0]   resp_instr,
    output logic          resp_err,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_idx,
    input  logic [63:0]   ld_data
);

    localparam logic [63:0] DEPTH_BYTES = 64'(DEPTH_WORDS) * 64'd8;
    localparam logic [15:0] CNT_LOAD    = 16'(LATENCY - 1);

    imem_state_t state, state_nxt;
    logic [63:0] addr_q;
    logic [15:0] cnt;

    logic        accept;
    logic        capture;
    logic [63:0] cap_addr;
    logic [63:0] off;
    logic        in_range;
    logic        cap_err;
    logic [63:0] rd_data;

    assign req_ready  = (state == ST_IDLE) & ~rst;
    assign resp_valid = (state == ST_RESP);
    assign accept     = req_valid & req_ready;

    // With LATENCY 1 the capture happens on the accept edge, so the address
    // comes straight from the request rather than the latched copy.
    assign capture  = ((state == ST_IDLE) && accept && (LATENCY == 1)) ||
                      ((state == ST_WAIT) && (cnt == 16'd1));
    assign cap_addr = (state == ST_IDLE) ? req_addr : addr_q;
    assign off      = cap_addr - ADDR_BASE;
    assign in_range = (cap_addr >= ADDR_BASE) && (off < DEPTH_BYTES);
    assign cap_err  = ~in_range | (cap_addr[1:0] != 2'b00);

    ysyx_220053_imem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk     (clk),
        .wr_en   (ld_en),
        .wr_idx  (ld_idx),
        .wr_data (ld_data),
        .rd_idx  (off[AW+2:3]),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = (LATENCY == 1) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (cnt == 16'd1) state_nxt = ST_RESP;
            ST_RESP: if (resp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= 64'd0;
            cnt        <= 16'd0;
            resp_rdata <= 64'd0;
            resp_instr <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q <= req_addr;
                cnt    <= CNT_LOAD;
            end else if (state == ST_WAIT) begin
                cnt <= cnt - 16'd1;
            end

            if (capture) begin
                if (cap_err) begin
                    resp_rdata <= 64'd0;
                    resp_instr <= 32'd0;
                    resp_err   <= 1'b1;
                end else begin
                    resp_rdata <= rd_data;
                    resp_instr <= cap_addr[2] ? rd_data[63:32] : rd_data[31:0];
                    resp_err   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_220053_imem.sv
// tb/tb_ysyx_220053_imem.sv - directed self-checking bench for ysyx_220053_imem
module tb_ysyx_220053_imem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst = 1'b1;

    // a: LATENCY 2, DEPTH 1024
    logic        a_req_valid = 0, a_req_ready, a_resp_valid, a_resp_ready = 0, a_resp_err, a_ld_en = 0;
    logic [63:0] a_req_addr = 0, a_resp_rdata, a_ld_data = 0;
    logic [31:0] a_resp_instr;
    logic [9:0]  a_ld_idx = 0;

    // b: LATENCY 1, DEPTH 16
    logic        b_req_valid = 0, b_req_ready, b_resp_valid, b_resp_ready = 1, b_resp_err, b_ld_en = 0;
    logic [63:0] b_req_addr = 0, b_resp_rdata, b_ld_data = 0;
    logic [31:0] b_resp_instr;
    logic [3:0]  b_ld_idx = 0;

    // c: LATENCY 4, DEPTH 16
    logic        c_req_valid = 0, c_req_ready, c_resp_valid, c_resp_ready = 0, c_resp_err, c_ld_en = 0;
    logic [63:0] c_req_addr = 0, c_resp_rdata, c_ld_data = 0;
    logic [31:0] c_resp_instr;
    logic [3:0]  c_ld_idx = 0;

    ysyx_220053_imem #(.ADDR_BASE(64'h8000_0000), .DEPTH_WORDS(1024), .LATENCY(2)) u_a (
        .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(a_req_addr),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready), .resp_rdata(a_resp_rdata),
        .resp_instr(a_resp_instr), .resp_err(a_resp_err),
        .ld_en(a_ld_en), .ld_idx(a_ld_idx), .ld_data(a_ld_data));

    ysyx_220053_imem #(.ADDR_BASE(64'h8000_0000), .DEPTH_WORDS(16), .LATENCY(1)) u_b (
        .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_rdata(b_resp_rdata),
        .resp_instr(b_resp_instr), .resp_err(b_resp_err),
        .ld_en(b_ld_en), .ld_idx(b_ld_idx), .ld_data(b_ld_data));

    ysyx_220053_imem #(.ADDR_BASE(64'h8000_0000), .DEPTH_WORDS(16), .LATENCY(4)) u_c (
        .clk(clk), .rst(rst), .req_valid(c_req_valid), .req_ready(c_req_ready), .req_addr(c_req_addr),
        .resp_valid(c_resp_valid), .resp_ready(c_resp_ready), .resp_rdata(c_resp_rdata),
        .resp_instr(c_resp_instr), .resp_err(c_resp_err),
        .ld_en(c_ld_en), .ld_idx(c_ld_idx), .ld_data(c_ld_data));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_load(input logic [9:0] idx, input logic [63:0] data);
        a_ld_en = 1; a_ld_idx = idx; a_ld_data = data;
        tick();
        a_ld_en = 0;
    endtask

    // Issue one request on instance a, count edges from acceptance (inclusive)
    // to resp_valid, capture the response and then consume it.
    task automatic a_fetch(input logic [63:0] addr, output int edges, output logic [63:0] rd,
                           output logic [31:0] ins, output logic err);
        int guard = 0;
        while (!a_req_ready && guard < 50) begin tick(); guard++; end
        a_req_valid = 1; a_req_addr = addr;
        tick();
        a_req_valid = 0;
        edges = 1;
        while (!a_resp_valid && edges < 50) begin tick(); edges++; end
        rd = a_resp_rdata; ins = a_resp_instr; err = a_resp_err;
        checks++;
        if (!a_resp_valid) begin
            failures++;
            $display("FAIL a_fetch_timeout addr=%h resp_valid=%b required=1", addr, a_resp_valid);
        end
        a_resp_ready = 1;
        tick();
        a_resp_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        tick(); tick();
        checks++;
        if (a_req_ready !== 1'b0 || a_resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_handshake req_ready=%b resp_valid=%b required 0/0", a_req_ready, a_resp_valid);
        end
        checks++;
        if (a_resp_rdata !== 64'd0 || a_resp_instr !== 32'd0 || a_resp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs rdata=%h instr=%h err=%b required zeros", a_resp_rdata, a_resp_instr, a_resp_err);
        end
        rst = 0;
        #1;
        checks++;
        if (a_req_ready !== 1'b1 || b_req_ready !== 1'b1 || c_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release req_ready a=%b b=%b c=%b required 1", a_req_ready, b_req_ready, c_req_ready);
        end
    endtask

    task automatic test_basic();
        int e; logic [63:0] rd; logic [31:0] ins; logic er;
        a_load(10'd0, 64'h00100093_00000513);
        a_fetch(64'h8000_0000, e, rd, ins, er);
        checks++;
        if (e !== 2) begin
            failures++; $display("FAIL basic_latency edges=%0d required=2", e);
        end
        checks++;
        if (ins !== 32'h00000513 || er !== 1'b0 || rd !== 64'h00100093_00000513) begin
            failures++; $display("FAIL basic_low instr=%h err=%b rdata=%h required 00000513/0", ins, er, rd);
        end
        a_fetch(64'h8000_0004, e, rd, ins, er);
        checks++;
        if (ins !== 32'h00100093 || er !== 1'b0) begin
            failures++; $display("FAIL basic_high instr=%h err=%b required 00100093/0", ins, er);
        end
    endtask

    task automatic test_backpressure();
        int guard = 0;
        int bad = 0;
        a_load(10'd3, 64'hDEAD_BEEF_CAFE_F00D);
        a_req_valid = 1; a_req_addr = 64'h8000_0018;
        tick();
        a_req_valid = 0;
        while (!a_resp_valid && guard < 20) begin tick(); guard++; end
        for (int i = 0; i < 5; i++) begin
            if (a_resp_valid !== 1'b1 || a_req_ready !== 1'b0 ||
                a_resp_rdata !== 64'hDEAD_BEEF_CAFE_F00D || a_resp_instr !== 32'hCAFE_F00D || a_resp_err !== 1'b0)
                bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL backpressure_hold bad_cycles=%0d required=0", bad);
        end
        a_resp_ready = 1;
        tick();
        a_resp_ready = 0;
        checks++;
        if (a_req_ready !== 1'b1 || a_resp_valid !== 1'b0) begin
            failures++; $display("FAIL backpressure_release req_ready=%b resp_valid=%b required 1/0", a_req_ready, a_resp_valid);
        end
    endtask

    task automatic test_errors();
        int e; logic [63:0] rd; logic [31:0] ins; logic er;
        a_load(10'd1023, 64'h1111_2222_3333_4444);
        a_fetch(64'h8000_0002, e, rd, ins, er);
        checks++;
        if (er !== 1'b1 || rd !== 64'd0 || ins !== 32'd0) begin
            failures++; $display("FAIL err_misaligned err=%b rdata=%h instr=%h required 1/0/0", er, rd, ins);
        end
        a_fetch(64'h7FFF_FFFC, e, rd, ins, er);
        checks++;
        if (er !== 1'b1 || rd !== 64'd0) begin
            failures++; $display("FAIL err_below err=%b rdata=%h required 1/0", er, rd);
        end
        a_fetch(64'h8000_2000, e, rd, ins, er);
        checks++;
        if (er !== 1'b1 || rd !== 64'd0) begin
            failures++; $display("FAIL err_above err=%b rdata=%h required 1/0", er, rd);
        end
        a_fetch(64'h8000_1FFC, e, rd, ins, er);
        checks++;
        if (er !== 1'b0 || ins !== 32'h1111_2222) begin
            failures++; $display("FAIL last_word err=%b instr=%h required 0/11112222", er, ins);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] addrs [3];
        logic [63:0] datas [3];
        int resp_cyc [3];
        int k = 0;
        int r = 0;
        logic acc;
        addrs[0] = 64'h8000_0000; addrs[1] = 64'h8000_000C; addrs[2] = 64'h8000_0010;
        datas[0] = 64'hA0A0_0001_B0B0_0001;
        datas[1] = 64'hA0A0_0002_B0B0_0002;
        datas[2] = 64'hA0A0_0003_B0B0_0003;
        for (int i = 0; i < 3; i++) begin
            b_ld_en = 1; b_ld_idx = 4'(i); b_ld_data = datas[i];
            tick();
        end
        b_ld_en = 0;
        for (int i = 0; i < 12 && r < 3; i++) begin
            b_req_valid = (k < 3);
            b_req_addr  = (k < 3) ? addrs[k] : 64'd0;
            #0;
            acc = b_req_valid & b_req_ready;
            tick();
            if (acc) k++;
            if (b_resp_valid) begin
                logic [31:0] exp_i;
                exp_i = addrs[r][2] ? datas[r][63:32] : datas[r][31:0];
                checks++;
                if (b_resp_rdata !== datas[r] || b_resp_instr !== exp_i || b_resp_err !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_data_%0d rdata=%h instr=%h required %h/%h", r, b_resp_rdata, b_resp_instr, datas[r], exp_i);
                end
                resp_cyc[r] = cyc;
                r++;
            end
        end
        b_req_valid = 0;
        checks++;
        if (r != 3) begin
            failures++; $display("FAIL b2b_count responses=%0d required=3", r);
        end else begin
            checks++;
            if (resp_cyc[1] - resp_cyc[0] != 2 || resp_cyc[2] - resp_cyc[1] != 2) begin
                failures++;
                $display("FAIL b2b_spacing gaps=%0d,%0d required 2,2", resp_cyc[1] - resp_cyc[0], resp_cyc[2] - resp_cyc[1]);
            end
        end
    endtask

    // Instance c: accept at edge t, capture at edge t+3.
    task automatic c_race(input int wr_edge, input logic [63:0] new_data, output logic [63:0] got, output int edges);
        c_req_valid = 1; c_req_addr = 64'h8000_0028;
        tick();
        c_req_valid = 0;
        edges = 1;
        while (!c_resp_valid && edges < 20) begin
            c_ld_en = (edges == wr_edge); c_ld_idx = 4'd5; c_ld_data = new_data;
            tick();
            edges++;
        end
        c_ld_en = 0;
        got = c_resp_rdata;
        c_resp_ready = 1;
        tick();
        c_resp_ready = 0;
    endtask

    task automatic test_load_race();
        logic [63:0] got;
        int e;
        c_ld_en = 1; c_ld_idx = 4'd5; c_ld_data = 64'h0000_0000_AAAA_AAAA;
        tick();
        c_ld_en = 0;
        c_race(1, 64'h0000_0000_BBBB_BBBB, got, e);
        checks++;
        if (e !== 4) begin
            failures++; $display("FAIL race_latency edges=%0d required=4", e);
        end
        checks++;
        if (got !== 64'h0000_0000_BBBB_BBBB) begin
            failures++; $display("FAIL race_early_write rdata=%h required=00000000bbbbbbbb", got);
        end
        c_race(3, 64'h0000_0000_CCCC_CCCC, got, e);
        checks++;
        if (got !== 64'h0000_0000_BBBB_BBBB) begin
            failures++; $display("FAIL race_capture_write rdata=%h required=00000000bbbbbbbb", got);
        end
    endtask

    task automatic test_reset_mid_wait();
        int seen = 0;
        logic [63:0] got;
        int e;
        c_resp_ready = 1;
        c_req_valid = 1; c_req_addr = 64'h8000_0028;
        tick();
        c_req_valid = 0;
        tick();
        rst = 1;
        tick();
        rst = 0;
        checks++;
        if (c_resp_valid !== 1'b0 || c_resp_rdata !== 64'd0 || c_resp_instr !== 32'd0 || c_resp_err !== 1'b0) begin
            failures++;
            $display("FAIL midwait_outputs valid=%b rdata=%h instr=%h err=%b required zeros",
                     c_resp_valid, c_resp_rdata, c_resp_instr, c_resp_err);
        end
        for (int i = 0; i < 8; i++) begin
            if (c_resp_valid) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            failures++; $display("FAIL midwait_no_resp resp_cycles=%0d required=0", seen);
        end
        c_resp_ready = 0;
        c_race(0, 64'd0, got, e);
        checks++;
        if (got !== 64'h0000_0000_CCCC_CCCC) begin
            failures++; $display("FAIL midwait_mem_kept rdata=%h required=00000000cccccccc", got);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_errors();
        test_back_to_back();
        test_load_race();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time=%0t required finish earlier", $time);
        $fatal(1);
    end

endmodule
